// File: rtl/i2c_reg_writer.sv
// i2c_reg_writer: I2C master that performs one complete register write per request:
// START, 7-bit device address with the W bit, REG_BYTES register-address bytes
// (MSB byte first), 0..MAX_DATA data bytes (byte 0 first), then STOP. Every ACK
// is checked. On a NACK the transfer is aborted with STOP. SCL and SDA are both
// generated from sys_clk through a quarter-bit clock enable.
//
// Ports:
//   sys_clk   sole clock
//   rst       synchronous active-high reset
//   write     request, sampled only while idle
//   addr      7-bit device address
//   register  register address, 8*REG_BYTES bits, MSB byte sent first
//   data      payload, byte i = data[8i+:8], byte 0 sent first
//   len       data byte count (0 = pointer-only), clamped to MAX_DATA
//   busy      transaction in progress
//   done      one-cycle pulse when a transaction ends
//   nack      sticky until the next accept: some ACK was missing
//   scl_oe    1 = pull SCL low
//   sda_oe    1 = pull SDA low
//   sda_in    synchronised SDA pad level
module i2c_reg_writer #(
    parameter int CLK_DIV   = 125,
    parameter int REG_BYTES = 1,
    parameter int MAX_DATA  = 4,
    parameter int LEN_W     = $clog2(MAX_DATA + 1)
) (
    input  logic                    sys_clk,
    input  logic                    rst,
    input  logic                    write,
    input  logic [6:0]              addr,
    input  logic [8*REG_BYTES-1:0]  register,
    input  logic [8*MAX_DATA-1:0]   data,
    input  logic [LEN_W-1:0]        len,
    output logic                    busy,
    output logic                    done,
    output logic                    nack,
    output logic                    scl_oe,
    output logic                    sda_oe,
    input  logic                    sda_in
);

    localparam int NB = 1 + REG_BYTES + MAX_DATA;   // largest frame in bytes
    localparam int BW = $clog2(NB);
    localparam int DW = $clog2(CLK_DIV);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_ADDR  = 3'd2;
    localparam logic [2:0] S_REG   = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_STOP  = 3'd5;

    logic [2:0]       state, state_n;
    logic [1:0]       q, q_n;              // quarter within the current bit
    logic [3:0]       bitc, bitc_n;        // 0..7 data bits, 8 = ACK slot
    logic [BW-1:0]    bidx, bidx_n, bidx_inc, last_idx;
    logic [DW-1:0]    div;
    logic [7:0]       frame [NB];          // address byte, register bytes, data bytes
    logic [7:0]       cur;
    logic [LEN_W-1:0] len_c;
    logic             tick, accept, in_byte, ack_slot;
    logic             scl_n, sda_n;

    assign accept   = write && (state == S_IDLE);
    assign tick     = (state != S_IDLE) && (div == DW'(CLK_DIV - 1));
    assign in_byte  = (state == S_ADDR) || (state == S_REG) || (state == S_DATA);
    assign ack_slot = in_byte && (bitc == 4'd8);
    assign len_c    = (len > LEN_W'(MAX_DATA)) ? LEN_W'(MAX_DATA) : len;
    assign bidx_inc = bidx + 1'b1;

    // Byte position decides which phase the FSM reports.
    function automatic logic [2:0] byte_state(input logic [BW-1:0] idx);
        if (idx == '0)
            return S_ADDR;
        else if (idx <= BW'(REG_BYTES))
            return S_REG;
        else
            return S_DATA;
    endfunction

    always_comb begin
        state_n = state;
        q_n     = q;
        bitc_n  = bitc;
        bidx_n  = bidx;
        if (accept) begin
            state_n = S_START;
            q_n     = 2'd0;
            bitc_n  = 4'd0;
            bidx_n  = '0;
        end else if (tick) begin
            if (q != 2'd3) begin
                q_n = q + 2'd1;
            end else begin
                q_n = 2'd0;
                case (state)
                    S_START: begin
                        state_n = S_ADDR;
                        bitc_n  = 4'd0;
                        bidx_n  = '0;
                    end
                    S_ADDR, S_REG, S_DATA: begin
                        if (bitc != 4'd8) begin
                            bitc_n = bitc + 4'd1;
                        end else if (nack || (bidx == last_idx)) begin
                            // nack was cleared on accept, so it is set here only
                            // by a NACK sampled earlier in this transaction.
                            state_n = S_STOP;
                        end else begin
                            bitc_n  = 4'd0;
                            bidx_n  = bidx_inc;
                            state_n = byte_state(bidx_inc);
                        end
                    end
                    default: state_n = S_IDLE;   // S_STOP q3 ends the transaction
                endcase
            end
        end
    end

    // Line levels are decoded from the next state so they are registered
    // alongside it, leaving no combinational path to the pads.
    always_comb begin
        scl_n = 1'b0;
        sda_n = 1'b0;
        cur   = frame[bidx_n];
        case (state_n)
            S_START: begin
                sda_n = (q_n != 2'd0);
                scl_n = q_n[1];
            end
            S_ADDR, S_REG, S_DATA: begin
                scl_n = (q_n == 2'd0) || (q_n == 2'd3);
                sda_n = (bitc_n == 4'd8) ? 1'b0 : ~cur[3'd7 - bitc_n[2:0]];
            end
            S_STOP: begin
                sda_n = ~q_n[1];
                scl_n = (q_n == 2'd0);
            end
            default: begin
                scl_n = 1'b0;
                sda_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state    <= S_IDLE;
            q        <= 2'd0;
            bitc     <= 4'd0;
            bidx     <= '0;
            last_idx <= '0;
            div      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            nack     <= 1'b0;
            scl_oe   <= 1'b0;
            sda_oe   <= 1'b0;
        end else begin
            state  <= state_n;
            q      <= q_n;
            bitc   <= bitc_n;
            bidx   <= bidx_n;
            busy   <= (state_n != S_IDLE);
            done   <= tick && (state == S_STOP) && (q == 2'd3);
            scl_oe <= scl_n;
            sda_oe <= sda_n;

            if (accept || tick)
                div <= '0;
            else if (state != S_IDLE)
                div <= div + 1'b1;

            if (accept) begin
                nack     <= 1'b0;
                last_idx <= BW'(REG_BYTES) + BW'(len_c);
            end else if (tick && ack_slot && (q == 2'd2) && sda_in) begin
                nack <= 1'b1;
            end
        end
    end

    // Payload holding register; no reset needed, it is always loaded before use.
    always_ff @(posedge sys_clk) begin
        if (!rst && accept) begin
            frame[0] <= {addr, 1'b0};
            for (int i = 0; i < REG_BYTES; i++)
                frame[1 + i] <= register[8*(REG_BYTES-1-i) +: 8];
            for (int i = 0; i < MAX_DATA; i++)
                frame[1 + REG_BYTES + i] <= data[8*i +: 8];
        end
    end

endmodule
